// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared raster timing defaults and counter width helper
package video_pkg;

  localparam int DEF_H_ACTIVE = 16;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 2;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 16;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 1;
  localparam int DEF_V_BP     = 1;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/video_raster_timing.sv
// rtl/video_raster_timing.sv - x/y raster counters with active, sync and swap-point decode
module raster_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic active,
  output logic hsync_nxt,
  output logic vsync_nxt,
  output logic first_pixel,
  output logic last_pixel,
  output logic swap_point
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = cnt_width(H_TOTAL);
  localparam int YW = cnt_width(V_TOTAL);

  localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] HS_FIRST   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VS_FIRST   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Inclusive upper bounds keep the compares safe when a porch is zero.
  assign active      = (x <= X_ACT_LAST) && (y <= Y_ACT_LAST);
  assign hsync_nxt   = (x >= HS_FIRST) && (x <= HS_LAST);
  assign vsync_nxt   = (y >= VS_FIRST) && (y <= VS_LAST);
  assign first_pixel = (x == '0) && (y == '0);
  assign last_pixel  = (x == X_ACT_LAST) && (y == Y_ACT_LAST);
  assign swap_point  = en && (x == X_LAST) && (y == Y_ACT_LAST);

endmodule

// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - ping-pong frame buffer scanout with vblank bank swap handshake
module video_scanout
  import video_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  switch,
  output logic [ADDR_WIDTH-1:0] vADDR,
  input  logic [DATA_WIDTH-1:0] vDATA,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  logic active;
  logic hsync_nxt;
  logic vsync_nxt;
  logic first_pixel;
  logic last_pixel;
  logic swap_point;
  logic scan_active;
  logic do_swap;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  raster_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .active      (active),
    .hsync_nxt   (hsync_nxt),
    .vsync_nxt   (vsync_nxt),
    .first_pixel (first_pixel),
    .last_pixel  (last_pixel),
    .swap_point  (swap_point)
  );

  assign scan_active = en && active;
  assign do_swap     = swap_point && swap_req;
  assign vADDR       = addr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
    end else if (scan_active) begin
      addr_cnt <= last_pixel ? '0 : addr_cnt + 1'b1;
    end
  end

  // Output stage: everything lands one cycle after the counter state it decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      switch      <= 1'b0;
    end else begin
      pix_data    <= scan_active ? vDATA : '0;
      pix_valid   <= scan_active;
      frame_start <= en && first_pixel;
      swap_ack    <= do_swap;
      if (do_swap) begin
        switch <= ~switch;
      end
      if (en) begin
        hsync <= hsync_nxt;
        vsync <= vsync_nxt;
      end
    end
  end

endmodule
